// File: rtl/sdram_arbit.sv
// sdram_arbit: sole owner of the SDRAM pins; runs power-up init, then arbitrates
// refresh > write > read and generates the periodic refresh request.
module sdram_arbit #(
    parameter int REF_PERIOD = 390,
    parameter int TRP_CYC    = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [11:0] init_addr,
    input  logic [1:0]  init_ba,
    output logic        aref_en,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [11:0] aref_addr,
    output logic        ref_req,
    input  logic        wr_req,
    input  logic        rd_req,
    output logic        wr_en,
    output logic        rd_en,
    input  logic        wr_end,
    input  logic        rd_end,
    input  logic [3:0]  wr_cmd,
    input  logic [11:0] wr_addr,
    input  logic [1:0]  wr_ba,
    input  logic [3:0]  rd_cmd,
    input  logic [11:0] rd_addr,
    input  logic [1:0]  rd_ba,
    input  logic [15:0] wr_dq,
    input  logic        wr_dq_oe,
    output logic [3:0]  sdram_cmd,
    output logic [11:0] sdram_addr,
    output logic [1:0]  sdram_ba,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe
);
    localparam logic [3:0] NOP = 4'b0111, PRECHARGE = 4'b0010;
    localparam int CW = REF_PERIOD > 1 ? $clog2(REF_PERIOD) : 1;
    localparam int TW = TRP_CYC > 1 ? $clog2(TRP_CYC) : 1;

    typedef enum logic [2:0] {INIT, ARBIT, AREF, WRITE, READ, YIELD} state_t;

    state_t        state, nxt;
    logic [CW-1:0] ref_cnt;
    logic [TW-1:0] trp_cnt;
    logic          yield_src;
    logic          wrap, use_wr, use_rd;

    assign wrap   = state != INIT && ref_cnt == CW'(REF_PERIOD - 1);
    assign use_wr = state == WRITE || (state == YIELD && !yield_src);
    assign use_rd = state == READ || (state == YIELD && yield_src);

    // A client yields to refresh by issuing PRECHARGE; its *_end still wins.
    always_comb begin
        nxt = state;
        case (state)
            INIT:    nxt = init_end ? ARBIT : INIT;
            ARBIT:   nxt = ref_req ? AREF : wr_req ? WRITE : rd_req ? READ : ARBIT;
            AREF:    nxt = aref_end ? ARBIT : AREF;
            WRITE:   nxt = wr_end ? ARBIT : (ref_req && wr_cmd == PRECHARGE) ? YIELD : WRITE;
            READ:    nxt = rd_end ? ARBIT : (ref_req && rd_cmd == PRECHARGE) ? YIELD : READ;
            YIELD:   nxt = trp_cnt == TW'(TRP_CYC - 1) ? ARBIT : YIELD;
            default: nxt = INIT;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst)
        if (!sys_rst) begin
            state     <= INIT;
            ref_cnt   <= '0;
            trp_cnt   <= '0;
            yield_src <= 1'b0;
            ref_req   <= 1'b0;
            aref_en   <= 1'b0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
        end else begin
            state   <= nxt;
            aref_en <= nxt == AREF;
            wr_en   <= nxt == WRITE;
            rd_en   <= nxt == READ;
            ref_cnt <= (state == INIT || wrap) ? '0 : ref_cnt + 1'b1;
            ref_req <= wrap | (ref_req & ~aref_end);
            trp_cnt <= state == YIELD ? trp_cnt + 1'b1 : '0;
            if (nxt == YIELD && state != YIELD)
                yield_src <= state == READ;
        end

    assign {sdram_cmd, sdram_addr, sdram_ba} =
        state == INIT ? {init_cmd, init_addr, init_ba} :
        state == AREF ? {aref_cmd, aref_addr, 2'b00} :
        use_wr        ? {wr_cmd, wr_addr, wr_ba} :
        use_rd        ? {rd_cmd, rd_addr, rd_ba} : {NOP, 12'd0, 2'd0};

    assign sdram_dq_out = wr_dq;
    assign sdram_dq_oe  = use_wr & wr_dq_oe;
endmodule
